// File: rtl/conv3x3_shift_engine_if.sv
// Control/status handshake and SRAM bus of the 3x3 shift-weighted convolution engine.
// The slave modport is the engine's view. The master modport is the view of
// whatever drives start/k_shift and supplies the SRAM read data.
interface conv3x3_shift_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 19
) ();
    logic              start;
    logic [35:0]       k_shift;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              res_valid;
    logic              mem_csn;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  start, k_shift, mem_dout,
        output busy, done, result, res_valid, mem_csn, mem_wen, mem_addr, mem_din
    );

    modport master (
        output start, k_shift, mem_dout,
        input  busy, done, result, res_valid, mem_csn, mem_wen, mem_addr, mem_din
    );
endinterface

// File: rtl/conv3x3_shift_engine.sv
// 3x3 shift-weighted convolution engine over an image held in single-port SRAM.
// Each interior pixel takes 11 cycles: 9 neighbour reads, one flush cycle that
// absorbs the last read's data, and one destination write. Tap t (t=(dy+1)*3+(dx+1))
// contributes mem_dout >> k_shift[4t+3:4t]; a shift code of 4'hF disables the tap.
// All outputs are registered. mem_wen, mem_csn and res_valid are additionally
// gated by rst, so asserting reset during a write cycle suppresses that write.
module conv3x3_shift_engine #(
    parameter int IMG_W    = 512,
    parameter int IMG_H    = 512,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 19,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 262144,
    parameter int SAT      = 1
) (
    input logic                   clk,
    input logic                   rst,
    conv3x3_shift_engine_if.slave bus
);
    // Nine unshifted taps need at most four extra bits of headroom.
    localparam int ACC_W = DATA_W + 4;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);

    localparam logic [XW-1:0] X_FIRST = XW'(1);
    localparam logic [YW-1:0] Y_FIRST = YW'(1);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 2);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 2);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        FLUSH,
        WR,
        DONE
    } state_t;

    state_t            state;
    logic [3:0]        tap;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [35:0]       k_reg;
    logic [ACC_W-1:0]  acc;

    logic              busy_r;
    logic              done_r;
    logic [DATA_W-1:0] result_r;
    logic              rv_r;
    logic              csn_r;
    logic              wen_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] din_r;

    logic [3:0]        shift_tap;
    logic [3:0]        cur_shift;
    logic [ACC_W-1:0]  tap_data;
    logic [ACC_W-1:0]  acc_sum;
    logic [XW-1:0]     next_x;
    logic [YW-1:0]     next_y;

    // Source address of tap t around pixel (px,py); the tap index encodes the offset.
    function automatic logic [ADDR_W-1:0] src_addr(input logic [XW-1:0] px,
                                                  input logic [YW-1:0] py,
                                                  input logic [3:0]    t);
        int col;
        int row;
        col = int'(px) + (int'(t) % 3) - 1;
        row = int'(py) + (int'(t) / 3) - 1;
        return ADDR_W'(SRC_BASE + row * IMG_W + col);
    endfunction

    // Destination address of pixel (px,py).
    function automatic logic [ADDR_W-1:0] dst_addr(input logic [XW-1:0] px,
                                                  input logic [YW-1:0] py);
        return ADDR_W'(DST_BASE + int'(py) * IMG_W + int'(px));
    endfunction

    // Weighted contribution of one tap; shift code 4'hF removes the tap entirely.
    function automatic logic [ACC_W-1:0] tap_term(input logic [DATA_W-1:0] d,
                                                  input logic [3:0]        s);
        if (s == 4'hF) begin
            return '0;
        end
        return ACC_W'(d >> s);
    endfunction

    // Narrow the accumulator to pixel width, either clamping or dropping the carry bits.
    function automatic logic [DATA_W-1:0] clip(input logic [ACC_W-1:0] a);
        if (SAT != 0 && a[ACC_W-1:DATA_W] != '0) begin
            return '1;
        end
        return a[DATA_W-1:0];
    endfunction

    // Read data always belongs to the tap issued one cycle earlier; in FLUSH that is tap 8 itself.
    always_comb begin
        shift_tap = tap;
        if (state != FLUSH && tap != 4'd0) begin
            shift_tap = tap - 4'd1;
        end
        cur_shift = k_reg[{shift_tap, 2'b00} +: 4];
    end

    assign tap_data = tap_term(bus.mem_dout, cur_shift);
    assign acc_sum  = acc + tap_data;
    assign next_x   = (x == X_LAST) ? X_FIRST : x + XW'(1);
    assign next_y   = (x == X_LAST) ? y + YW'(1) : y;

    // Frame sequencer: raster walk over interior pixels with registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            tap      <= 4'd0;
            x        <= X_FIRST;
            y        <= Y_FIRST;
            k_reg    <= '0;
            acc      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            rv_r     <= 1'b0;
            csn_r    <= 1'b1;
            wen_r    <= 1'b0;
            addr_r   <= '0;
            din_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    rv_r   <= 1'b0;
                    wen_r  <= 1'b0;
                    csn_r  <= 1'b1;
                    if (bus.start) begin
                        k_reg  <= bus.k_shift;
                        busy_r <= 1'b1;
                        tap    <= 4'd0;
                        x      <= X_FIRST;
                        y      <= Y_FIRST;
                        csn_r  <= 1'b0;
                        addr_r <= src_addr(X_FIRST, Y_FIRST, 4'd0);
                        state  <= RD;
                    end
                end

                RD: begin
                    rv_r  <= 1'b0;
                    wen_r <= 1'b0;
                    if (tap == 4'd1) begin
                        acc <= tap_data;
                    end else if (tap != 4'd0) begin
                        acc <= acc_sum;
                    end
                    if (tap == 4'd8) begin
                        csn_r <= 1'b1;
                        state <= FLUSH;
                    end else begin
                        tap    <= tap + 4'd1;
                        addr_r <= src_addr(x, y, tap + 4'd1);
                    end
                end

                FLUSH: begin
                    acc      <= acc_sum;
                    csn_r    <= 1'b0;
                    wen_r    <= 1'b1;
                    addr_r   <= dst_addr(x, y);
                    din_r    <= clip(acc_sum);
                    result_r <= clip(acc_sum);
                    rv_r     <= 1'b1;
                    state    <= WR;
                end

                WR: begin
                    wen_r <= 1'b0;
                    rv_r  <= 1'b0;
                    if (x == X_LAST && y == Y_LAST) begin
                        csn_r  <= 1'b1;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        x      <= X_FIRST;
                        y      <= Y_FIRST;
                        state  <= DONE;
                    end else begin
                        tap    <= 4'd0;
                        x      <= next_x;
                        y      <= next_y;
                        addr_r <= src_addr(next_x, next_y, 4'd0);
                        state  <= RD;
                    end
                end

                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    csn_r  <= 1'b1;
                    wen_r  <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.res_valid = rv_r & rst;
    assign bus.mem_csn   = csn_r | ~rst;
    assign bus.mem_wen   = wen_r & rst;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_din   = din_r;
endmodule
